// File: rtl/cpu_types_pkg.sv
// Shared execute-stage types for the iterative multiply/divide unit.
package cpu_types_pkg;

   localparam int MULDIV_ITER = 32;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } muldiv_state_t;

   // Operand facts captured at start; the neg flags are only ever set for signed ops.
   typedef struct packed {
      logic a_neg;
      logic b_neg;
      logic b_zero;
   } md_flags_t;

   function automatic logic is_mul(input muldiv_op_t op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic is_signed_op(input muldiv_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional negation of the unsigned {hi, lo} result from the iterative core.
module muldiv_sign_fix
   import cpu_types_pkg::*;
(
   input  muldiv_op_t  op,
   input  md_flags_t   flags,
   input  logic [63:0] res_i,
   output logic [63:0] res_o
);

   // NOTE: assign a default before any branch so no path leaves res_o unassigned (latch).
   always_comb begin
      res_o = res_i;
      if (is_mul(op)) begin
         if (flags.a_neg ^ flags.b_neg) res_o = -res_i;
      end else begin
         // A zero divisor leaves the all-ones quotient untouched.
         if ((flags.a_neg ^ flags.b_neg) && !flags.b_zero) res_o[31:0] = -res_i[31:0];
         if (flags.a_neg) res_o[63:32] = -res_i[63:32];
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Define MULDIV_FAST_MULT_EN for a single-cycle multiplier (divide stays iterative).
module ex_muldiv
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        nRST,
   input  logic        start,
   input  muldiv_op_t  op,
   input  logic [31:0] rdat1,
   input  logic [31:0] rdat2,
   input  logic        flush,
   output logic        stall,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   muldiv_state_t state_q, state_d;
   muldiv_op_t    op_q, op_d;
   md_flags_t     flags_q, flags_d;
   logic [5:0]    cnt_q, cnt_d;
   logic [31:0]   opa_q, opa_d;
   logic [63:0]   acc_q, acc_d;
   logic [32:0]   rem_q, rem_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;

   logic [32:0]   mul_sum;
   logic [33:0]   div_diff;
   logic [63:0]   fix_in, fix_out;
   logic          in_sgn;
   logic          fast_mul;
   logic [63:0]   fast_prod;

   assign in_sgn = is_signed_op(op);

`ifdef MULDIV_FAST_MULT_EN
   // Sign-extended operands make the truncated unsigned product correct for MD_MULT too.
   assign fast_mul  = is_mul(op);
   assign fast_prod = {{32{in_sgn & rdat1[31]}}, rdat1} * {{32{in_sgn & rdat2[31]}}, rdat2};
`else
   assign fast_mul  = 1'b0;
   assign fast_prod = '0;
`endif

   // Multiply: acc = {partial product, remaining multiplier bits}.
   assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
   // Divide: acc[31:0] shifts dividend bits out and quotient bits in.
   assign div_diff = {rem_q, acc_q[31]} - {2'b00, opa_q};
   assign fix_in   = is_mul(op_q) ? acc_q : {rem_q[31:0], acc_q[31:0]};

   muldiv_sign_fix u_sign_fix (
      .op    (op_q),
      .flags (flags_q),
      .res_i (fix_in),
      .res_o (fix_out)
   );

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      flags_d = flags_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         IDLE: begin
            if (start && !flush) begin
               op_d           = op;
               flags_d.a_neg  = in_sgn & rdat1[31];
               flags_d.b_neg  = in_sgn & rdat2[31];
               flags_d.b_zero = (rdat2 == 32'd0);
               cnt_d          = '0;
               rem_d          = '0;
               if (fast_mul) begin
                  {hi_d, lo_d} = fast_prod;
                  state_d      = DONE;
               end else begin
                  opa_d   = is_mul(op) ? mag32(rdat1, in_sgn) : mag32(rdat2, in_sgn);
                  acc_d   = {32'd0, is_mul(op) ? mag32(rdat2, in_sgn) : mag32(rdat1, in_sgn)};
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 6'd1;
               if (is_mul(op_q)) begin
                  acc_d = {mul_sum, acc_q[31:1]};
               end else if (!div_diff[33]) begin
                  rem_d        = div_diff[32:0];
                  acc_d[31:0]  = {acc_q[30:0], 1'b1};
               end else begin
                  rem_d        = {rem_q[31:0], acc_q[31]};
                  acc_d[31:0]  = {acc_q[30:0], 1'b0};
               end
               if (cnt_q == 6'(MULDIV_ITER - 1)) state_d = SIGN;
            end
         end
         SIGN: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               {hi_d, lo_d} = fix_out;
               state_d      = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         op_q    <= MD_MULT;
         flags_q <= '0;
         cnt_q   <= '0;
         opa_q   <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy  = (state_q == CALC) || (state_q == SIGN);
   assign done  = (state_q == DONE);
   assign stall = (start && (state_q == IDLE)) || busy;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv (default iterative build).
module tb_ex_muldiv;
   import cpu_types_pkg::*;

   logic        CLK;
   logic        nRST;
   logic        start;
   muldiv_op_t  op;
   logic [31:0] rdat1;
   logic [31:0] rdat2;
   logic        flush;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   ex_muldiv dut (
      .CLK   (CLK),
      .nRST  (nRST),
      .start (start),
      .op    (op),
      .rdat1 (rdat1),
      .rdat2 (rdat2),
      .flush (flush),
      .stall (stall),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Holds start high until done is seen, as ID/EX would while stalled.
   task automatic run_op(input string tag, input muldiv_op_t o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      n     = 0;
      op    = o;
      rdat1 = a;
      rdat2 = b;
      start = 1'b1;
      #1;
      check({tag, "_stall_start"}, 64'(stall), 64'd1);
      do begin
         tick();
         n++;
         if (n == 1) check({tag, "_busy"}, 64'(busy), 64'd1);
      end while (!done && n < 100);
      start = 1'b0;
      check({tag, "_latency"}, 64'(n), 64'd34);
      check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
      check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
      tick();
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int n_done;
      nRST  = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = MD_MULTU;
      rdat1 = '0;
      rdat2 = '0;
      repeat (3) tick();
      nRST = 1'b1;
      tick();
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);

      run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult_neg",  MD_MULT,  32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_zero", MD_DIVU,  32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF);
      run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

      // Abort: DIVU 100/7 flushed in CALC; HI/LO keep the overflow result.
      op    = MD_DIVU;
      rdat1 = 32'd100;
      rdat2 = 32'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      check("flush_busy_before", 64'(busy), 64'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_busy_after", 64'(busy), 64'd0);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) n_done++;
         tick();
      end
      check("flush_no_done", 64'(n_done), 64'd0);
      check("flush_hi_kept", 64'(hi), 64'd0);
      check("flush_lo_kept", 64'(lo), 64'h8000_0000);

      // Restart with start held through busy: exactly one completion.
      run_op("divu_restart", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         if (done || busy) n_done++;
         tick();
      end
      check("restart_single_done", 64'(n_done), 64'd0);

      // Reset mid-operation discards everything.
      op    = MD_MULTU;
      rdat1 = 32'd5;
      rdat2 = 32'd6;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      nRST = 1'b0;
      #1;
      check("midrst_hi", 64'(hi), 64'd0);
      check("midrst_lo", 64'(lo), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      tick();
      nRST = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

- Iterative multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded MULT/MULTU/DIV/DIVU operation and both register operands held in ID/EX.
- Computes a 64-bit result over multiple cycles and holds it in architectural HI/LO registers, which are read by MFHI/MFLO.
- While an operation is in flight it drives a stall so the hazard logic holds ID/EX and earlier stages.

## Interface
- ITER, 32: iteration count for radix-2 multiply/divide; equals the word width.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset; asynchronous, active-low.
- start  in  1  request from ID/EX outputs; sampled only in IDLE.
- op  in  2  muldiv_op_t: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
- rdat1  in  32  rs operand (multiplicand / dividend).
- rdat2  in  32  rt operand (multiplier / divisor).
- flush  in  1  abort in-flight operation (branch/jump squash).
- stall  out  1  combinational: (start & IDLE) | CALC | SIGN.
- busy  out  1  registered: state is CALC or SIGN.
- done  out  1  one-cycle pulse when hi/lo update.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE with start=1:
  - Latch |rdat1| and |rdat2|; take magnitudes only for MD_MULT/MD_DIV, raw values for unsigned ops.
  - Latch the result-sign flags and op.
  - Clear counter cnt (6 bits); go to CALC.
- CALC multiply: shift-add, 1 bit/cycle, into a 64-bit accumulator.
- CALC divide: restoring division, 1 quotient bit/cycle, remainder in a 33-bit register.
- CALC exit: when cnt reaches ITER-1, go to SIGN.
- SIGN, signed multiply: negate the 64-bit product if the operand signs differ.
- SIGN, signed divide:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
- SIGN result write:
  - Multiply: hi = product[63:32], lo = product[31:0].
  - Divide: hi = remainder, lo = quotient.
  - Go to DONE.
- DONE: done=1 for one cycle; go to IDLE. start is not accepted in DONE.
- start while busy or DONE: ignored (no queuing).
- Divide by zero: no trap, latency unchanged; hi = rdat1 as latched (raw), lo = 32'hFFFFFFFF.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- flush=1 in CALC/SIGN: go to IDLE next edge; hi/lo unchanged; no done.
- flush in IDLE: start is ignored that cycle.
- flush in DONE: hi/lo are already written and stay written.
- Reset values: state IDLE, hi=0, lo=0, done=0, busy=0, internal accumulators 0.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.

## Timing
- start sampled at edge E.
- busy high after E through edge E+33.
- hi/lo written at edge E+33; done high for the cycle after E+33.
- Total latency is 34 cycles from start to done.
- stall is high in the start cycle, so ID/EX holds the instruction and drops start only after the cycle in which done is high.
- A new start is accepted at the earliest in the cycle after done.

## Configuration
- MULDIV_FAST_MULT_EN defined:
  - MD_MULT/MD_MULTU use a single-cycle 32x32 multiplier.
  - IDLE→DONE at edge E; hi/lo written at E; done high the following cycle; busy never asserts for multiply.
  - Divide is unchanged.
- MULDIV_FAST_MULT_EN undefined: all four ops use the iterative 34-cycle path above.

## Structure
- cpu_types_pkg gains:
  - muldiv_op_t (2-bit enum).
  - muldiv_state_t (IDLE, CALC, SIGN, DONE).
  - localparam MULDIV_ITER = 32.
- One sub-module, muldiv_sign_fix: combinational conditional negation of a 64-bit {hi, lo} result, driven by the sign flags and op.

## Test plan
- Reset → hi=0, lo=0, done=0, busy=0, stall=0.
- MD_MULTU 0xFFFFFFFF×0xFFFFFFFF → done exactly 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
- MD_MULT -7×3 (0xFFFFFFF9, 3) → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MD_DIV -7÷2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- MD_DIVU 0x12345678÷0 → lo=0xFFFFFFFF, hi=0x12345678, same 34-cycle latency.
- Signed overflow: MD_DIV 0x80000000÷0xFFFFFFFF → lo=0x80000000, hi=0.
- Abort and restart:
  - Start MD_DIVU 100÷7, flush at cycle 10 → IDLE, no done, hi/lo keep prior values.
  - Restart with a second start held high during busy → only one done; lo=14, hi=2.
